// File: rtl/seq_divider.sv
// Purpose : multi-cycle restoring divider, unsigned or two's-complement, with zero/overflow flags and abort.
// Latency : done after WIDTH+3 edges (counting the edge that samples start); 2 edges for div-by-zero/overflow.
// Backpressure: none; start is accepted only in IDLE, any other start is dropped, clear aborts at once.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             clear,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // registered copies of the request; inputs may change after the start edge
   logic [WIDTH-1:0] op_dvd;
   logic [WIDTH-1:0] op_dvs;
   logic             op_signed;

   // iteration working set
   logic [WIDTH-1:0] work_dvd;   // dividend magnitude, shifted out MSB first
   logic [WIDTH-1:0] work_dvs;   // divisor magnitude
   logic [WIDTH-1:0] part_rem;   // partial remainder, always < work_dvs between steps
   logic [WIDTH-1:0] work_quo;
   logic [CNT_W-1:0] cnt;
   logic             neg_quo;
   logic             neg_rem;

   logic             is_zero;
   logic             is_ovf;
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // special-case detection and the trial subtraction of one restoring step
   always_comb begin
      is_zero = (op_dvs == '0);
      is_ovf  = op_signed && (op_dvd == MIN_NEG) && (op_dvs == ONES);
      dvd_neg = op_signed & op_dvd[WIDTH-1];
      dvs_neg = op_signed & op_dvs[WIDTH-1];
      shifted = {part_rem, work_dvd[WIDTH-1]};
      trial   = shifted - {1'b0, work_dvs};
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic; clear overrides everything, including a concurrent start
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = (is_zero || is_ovf) ? S_DONE : S_ITER;
            S_ITER:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // status outputs decoded from the current state
   always_comb begin
      busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
      done = (state == S_DONE);
   end

   // datapath: operand capture, special cases, one quotient bit per ITER cycle, sign fix-up
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_dvd      <= '0;
         op_dvs      <= '0;
         op_signed   <= 1'b0;
         work_dvd    <= '0;
         work_dvs    <= '0;
         part_rem    <= '0;
         work_quo    <= '0;
         cnt         <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (clear) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_dvd      <= dividend;
                  op_dvs      <= divisor;
                  op_signed   <= signed_mode;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            S_PREP: begin
               if (is_zero) begin
                  quotient    <= ONES;
                  remainder   <= op_dvd;
                  div_by_zero <= 1'b1;
               end else if (is_ovf) begin
                  quotient    <= MIN_NEG;
                  remainder   <= '0;
                  overflow    <= 1'b1;
               end else begin
                  // the magnitude of the most-negative value still fits as unsigned
                  work_dvd <= dvd_neg ? (~op_dvd + 1'b1) : op_dvd;
                  work_dvs <= dvs_neg ? (~op_dvs + 1'b1) : op_dvs;
                  part_rem <= '0;
                  work_quo <= '0;
                  cnt      <= CNT_W'(WIDTH - 1);
                  neg_quo  <= dvd_neg ^ dvs_neg;
                  neg_rem  <= dvd_neg;
               end
            end
            S_ITER: begin
               work_dvd <= {work_dvd[WIDTH-2:0], 1'b0};
               cnt      <= cnt - CNT_W'(1);
               if (!trial[WIDTH]) begin
                  part_rem <= trial[WIDTH-1:0];
                  work_quo <= {work_quo[WIDTH-2:0], 1'b1};
               end else begin
                  part_rem <= shifted[WIDTH-1:0];
                  work_quo <= {work_quo[WIDTH-2:0], 1'b0};
               end
            end
            S_FIX: begin
               // quotient truncates toward zero; remainder follows the dividend's sign
               quotient  <= neg_quo ? (~work_quo + 1'b1) : work_quo;
               remainder <= neg_rem ? (~part_rem + 1'b1) : part_rem;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
